// File: rtl/gray_counter_ctrl.sv
// Run/pause/step controller for the Gray-coded LED counter.
// Generates the divided count tick and sequences a binary count from button edges.
module gray_counter_ctrl #(
    parameter int N        = 4,
    parameter int DISTANCE = 100000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         step,
    input  logic         dir,
    output logic         clk_en,
    output logic [N-1:0] leds,
    output logic [1:0]   state,
    output logic         wrap
);

    localparam int DW = $clog2(DISTANCE);
    localparam logic [DW-1:0] DIV_LAST = DW'(DISTANCE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_BAD   = 2'b11
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [DW-1:0]  r_div;
    logic [DW-1:0]  w_div_nxt;
    logic [N-1:0]   r_bin;
    logic [N-1:0]   w_bin_nxt;
    logic [N-1:0]   r_leds;
    logic           r_wrap;
    logic           w_wrap_nxt;
    logic           r_start_q;
    logic           r_stop_q;
    logic           r_step_q;
    logic           w_rise_start;
    logic           w_rise_stop;
    logic           w_rise_step;
    logic           w_tick;
    logic           w_adv;
    logic           w_clear;

    assign w_rise_start = start & ~r_start_q;
    assign w_rise_stop  = stop  & ~r_stop_q;
    assign w_rise_step  = step  & ~r_step_q;

    // A stop taken in the terminal divider cycle suppresses that cycle's tick.
    assign w_tick = (r_state == S_RUN) && (r_div == DIV_LAST) && !w_rise_stop;

    assign w_div_nxt = (r_state == S_RUN && !w_rise_stop)
                     ? ((r_div == DIV_LAST) ? '0 : r_div + 1'b1)
                     : '0;

    assign w_bin_nxt  = dir ? (r_bin - 1'b1) : (r_bin + 1'b1);
    assign w_wrap_nxt = w_adv & (dir ? (r_bin == '0) : (r_bin == '1));

    // Command priority: stop over start over step.
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise_stop)       w_clear = 1'b1;
                else if (w_rise_start) w_state_nxt = S_RUN;
                else if (w_rise_step)  w_adv = 1'b1;
            end
            S_RUN: begin
                if (w_rise_stop)       w_state_nxt = S_PAUSE;
                else if (w_tick)       w_adv = 1'b1;
            end
            S_PAUSE: begin
                if (w_rise_stop) begin
                    w_state_nxt = S_IDLE;
                    w_clear     = 1'b1;
                end
                else if (w_rise_start) w_state_nxt = S_RUN;
                else if (w_rise_step)  w_adv = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bin     <= '0;
            r_leds    <= '0;
            r_wrap    <= 1'b0;
            r_start_q <= start;
            r_stop_q  <= stop;
            r_step_q  <= step;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_wrap    <= w_wrap_nxt;
            r_start_q <= start;
            r_stop_q  <= stop;
            r_step_q  <= step;
            if (w_clear) begin
                r_bin  <= '0;
                r_leds <= '0;
            end else if (w_adv) begin
                r_bin  <= w_bin_nxt;
                r_leds <= w_bin_nxt ^ (w_bin_nxt >> 1);
            end
        end
    end

    assign clk_en = w_tick;
    assign leds   = r_leds;
    assign state  = r_state;
    assign wrap   = r_wrap;

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Directed bench for gray_counter_ctrl with DISTANCE=4: expected output words
// are queued per cycle and checked by an independent negedge monitor.
module tb_gray_counter_ctrl;

    localparam int N = 4;
    localparam int D = 4;
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;

    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    logic         step;
    logic         dir;
    logic         clk_en;
    logic [N-1:0] leds;
    logic [1:0]   state;
    logic         wrap;

    logic [7:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] gray_tab [16];

    gray_counter_ctrl #(.N(N), .DISTANCE(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .step   (step),
        .dir    (dir),
        .clk_en (clk_en),
        .leds   (leds),
        .state  (state),
        .wrap   (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: word layout {clk_en, wrap, state[1:0], leds[3:0]}
    always @(negedge clk) begin
        logic [7:0] e;
        logic [7:0] a;
        string      nm;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {clk_en, wrap, state, leds};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got ce=%b wrap=%b state=%b leds=%b, expected ce=%b wrap=%b state=%b leds=%b",
                         nm, a[7], a[6], a[5:4], a[3:0], e[7], e[6], e[5:4], e[3:0]);
            end
        end
    end

    function automatic logic [7:0] pk(input logic ce, input logic wr,
                                      input logic [1:0] st, input logic [3:0] ld);
        return {ce, wr, st, ld};
    endfunction

    task automatic drive(input logic r, input logic st, input logic sp,
                         input logic stp, input logic d);
        rst   = r;
        start = st;
        stop  = sp;
        step  = stp;
        dir   = d;
    endtask

    // Apply the driven inputs across one rising edge, then expect the outputs.
    task automatic cyc(input logic [7:0] e, input string nm);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        #1;
    endtask

    initial begin
        gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        // Reset held with start high: no edge after release
        drive(0, 1, 0, 0, 0);
        repeat (3) cyc(pk(0, 0, IDLE, 4'b0000), "reset");
        drive(1, 1, 0, 0, 0);
        cyc(pk(0, 0, IDLE, 4'b0000), "held_start_no_edge");
        cyc(pk(0, 0, IDLE, 4'b0000), "held_start_no_edge");
        drive(1, 0, 0, 0, 0);
        cyc(pk(0, 0, IDLE, 4'b0000), "idle_quiet");

        // Run up: tick on every 4th RUN cycle, wrap after 16 ticks
        drive(1, 1, 0, 0, 0);
        cyc(pk(0, 0, RUN, 4'b0000), "run_enter");
        drive(1, 0, 0, 0, 0);
        for (int k = 2; k <= 78; k++)
            cyc(pk(k % 4 == 0, k == 65, RUN, gray_tab[((k - 1) / 4) % 16]), "run_up");

        // Pause at bin 3, then a held step advances once
        drive(1, 0, 1, 0, 0);
        cyc(pk(0, 0, PAUSE, gray_tab[3]), "stop_to_pause");
        drive(1, 0, 0, 0, 1);
        cyc(pk(0, 0, PAUSE, gray_tab[3]), "pause_hold");
        cyc(pk(0, 0, PAUSE, gray_tab[3]), "pause_hold");
        drive(1, 0, 0, 1, 1);
        repeat (10) cyc(pk(0, 0, PAUSE, gray_tab[2]), "pause_step_held");
        drive(1, 0, 0, 0, 1);
        cyc(pk(0, 0, PAUSE, gray_tab[2]), "pause_after_step");

        // Resume, step ignored in RUN, down tick uses dir
        drive(1, 1, 0, 0, 1);
        cyc(pk(0, 0, RUN, gray_tab[2]), "resume");
        drive(1, 0, 0, 1, 1);
        cyc(pk(0, 0, RUN, gray_tab[2]), "step_in_run");
        drive(1, 0, 0, 0, 1);
        cyc(pk(0, 0, RUN, gray_tab[2]), "run_div2");
        cyc(pk(1, 0, RUN, gray_tab[2]), "run_tick_down");
        cyc(pk(0, 0, RUN, gray_tab[1]), "run_down_adv");
        drive(1, 0, 1, 0, 1);
        cyc(pk(0, 0, PAUSE, gray_tab[1]), "stop_pause2");
        drive(1, 0, 0, 0, 1);
        cyc(pk(0, 0, PAUSE, gray_tab[1]), "pause_hold2");
        drive(1, 0, 1, 0, 1);
        cyc(pk(0, 0, IDLE, 4'b0000), "stop_clear");
        drive(1, 0, 0, 0, 1);
        cyc(pk(0, 0, IDLE, 4'b0000), "idle_after_clear");

        // Down wrap by step from IDLE
        drive(1, 0, 0, 1, 1);
        cyc(pk(0, 1, IDLE, 4'b1000), "down_wrap");
        drive(1, 0, 0, 0, 1);
        cyc(pk(0, 0, IDLE, 4'b1000), "wrap_one_cycle");

        // Step up 15 -> 0 (wrap) then on to 5
        for (int b = 0; b <= 5; b++) begin
            drive(1, 0, 0, 1, 0);
            cyc(pk(0, b == 0, IDLE, gray_tab[b]), "step_up");
            drive(1, 0, 0, 0, 0);
            cyc(pk(0, 0, IDLE, gray_tab[b]), "step_up_release");
        end

        // Simultaneous start+stop: stop wins from PAUSE and from IDLE
        drive(1, 1, 0, 0, 0);
        cyc(pk(0, 0, RUN, gray_tab[5]), "run_at5");
        drive(1, 0, 1, 0, 0);
        cyc(pk(0, 0, PAUSE, gray_tab[5]), "pause_at5");
        drive(1, 0, 0, 0, 0);
        cyc(pk(0, 0, PAUSE, gray_tab[5]), "pause_at5_hold");
        drive(1, 1, 1, 0, 0);
        cyc(pk(0, 0, IDLE, 4'b0000), "simul_from_pause");
        drive(1, 0, 0, 0, 0);
        cyc(pk(0, 0, IDLE, 4'b0000), "idle_quiet2");
        drive(1, 1, 1, 0, 0);
        cyc(pk(0, 0, IDLE, 4'b0000), "simul_from_idle");
        drive(1, 0, 0, 0, 0);
        cyc(pk(0, 0, IDLE, 4'b0000), "idle_quiet3");

        // Reset mid-RUN with divider at 2, then fresh tick timing
        for (int b = 1; b <= 2; b++) begin
            drive(1, 0, 0, 1, 0);
            cyc(pk(0, 0, IDLE, gray_tab[b]), "pre_step");
            drive(1, 0, 0, 0, 0);
            cyc(pk(0, 0, IDLE, gray_tab[b]), "pre_step_release");
        end
        drive(1, 1, 0, 0, 0);
        cyc(pk(0, 0, RUN, gray_tab[2]), "run_enter2");
        drive(1, 0, 0, 0, 0);
        cyc(pk(0, 0, RUN, gray_tab[2]), "run2_div1");
        cyc(pk(0, 0, RUN, gray_tab[2]), "run2_div2");
        drive(0, 0, 0, 0, 0);
        cyc(pk(0, 0, IDLE, 4'b0000), "reset_mid_run");
        drive(1, 0, 0, 0, 0);
        cyc(pk(0, 0, IDLE, 4'b0000), "after_reset");
        drive(1, 1, 0, 0, 0);
        cyc(pk(0, 0, RUN, 4'b0000), "restart");
        drive(1, 0, 0, 0, 0);
        cyc(pk(0, 0, RUN, 4'b0000), "restart_div1");
        cyc(pk(0, 0, RUN, 4'b0000), "restart_div2");
        cyc(pk(1, 0, RUN, 4'b0000), "first_tick_after_reset");
        cyc(pk(0, 0, RUN, gray_tab[1]), "adv_after_reset");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
